noc_ni_tx: RTL and testbench

Transmit-side network interface that converts messages from a processing element (PE) into wormhole flits for the local injection port of a `mesh` router. Each message becomes one head flit (route plus length), then `msg_len` payload flits; the final payload flit is marked tail. A small payload FIFO decouples the PE from network backpressure, and a registered output stage drives the router's valid/ready link.

---
 rtl/noc_ni_tx.sv | 239 +++++++++++++++++++++++
 tb/tb_noc_ni_tx.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_ni_tx.sv
// Transmit network interface: PE messages become head/body/tail wormhole flits for a mesh router injection port.
// Optional per-node flit/packet counters are enabled with `define NOC_NI_STATS_EN.
module noc_ni_tx #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned X_W        = 2,
    parameter int unsigned Y_W        = 2,
    parameter int unsigned SRC_X      = 0,
    parameter int unsigned SRC_Y      = 0,
    parameter int unsigned LEN_W      = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              msg_valid,
    output logic              msg_ready,
    input  logic [X_W-1:0]    msg_dx,
    input  logic [Y_W-1:0]    msg_dy,
    input  logic [LEN_W-1:0]  msg_len,
    input  logic              pld_valid,
    output logic              pld_ready,
    input  logic [DATA_W-1:0] pld_data,
    output logic              flit_valid,
    input  logic              flit_ready,
    output logic [DATA_W+1:0] flit_data
`ifdef NOC_NI_STATS_EN
    ,
    output logic [15:0]       stat_pkts,
    output logic [15:0]       stat_flits
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [X_W-1:0] SRC_X_V = X_W'(SRC_X);
    localparam logic [Y_W-1:0] SRC_Y_V = Y_W'(SRC_Y);

    localparam logic [1:0] T_BODY = 2'b00;
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_HT   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEAD,
        S_BODY
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    logic [X_W-1:0]    r_dx;
    logic [Y_W-1:0]    r_dy;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_rem;

    logic              r_flit_valid;
    logic [DATA_W+1:0] r_flit_data;
    logic              w_free;
    logic              w_accept;
    logic              w_load;
    logic [1:0]        w_load_type;
    logic [DATA_W-1:0] w_load_body;
    logic [DATA_W-1:0] w_head_body;
    logic              w_rem_load;
    logic              w_rem_dec;

    // Payload FIFO; ready comes only from the registered count.
    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign pld_ready = !rst && !w_full;
    assign w_push    = pld_valid && pld_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= pld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_free      = !r_flit_valid || flit_ready;
    assign w_head_body = DATA_W'({r_dx, r_dy, SRC_X_V, SRC_Y_V, r_len});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (msg_valid) begin
                    w_state_nxt = S_HEAD;
                end
            end
            S_HEAD: begin
                if (w_free) begin
                    w_state_nxt = (r_len == '0) ? S_IDLE : S_BODY;
                end
            end
            S_BODY: begin
                if (w_free && !w_empty && (r_rem == LEN_W'(1))) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        msg_ready   = 1'b0;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        w_load_type = T_BODY;
        w_load_body = '0;
        w_pop       = 1'b0;
        w_rem_load  = 1'b0;
        w_rem_dec   = 1'b0;
        case (r_state)
            S_IDLE: begin
                msg_ready = !rst;
                w_accept  = msg_valid;
            end
            S_HEAD: begin
                if (w_free) begin
                    w_load      = 1'b1;
                    w_load_type = (r_len == '0) ? T_HT : T_HEAD;
                    w_load_body = w_head_body;
                    w_rem_load  = 1'b1;
                end
            end
            S_BODY: begin
                // An empty FIFO here leaves the stage idle: a bubble, not an abort.
                if (w_free && !w_empty) begin
                    w_load      = 1'b1;
                    w_pop       = 1'b1;
                    w_rem_dec   = 1'b1;
                    w_load_type = (r_rem == LEN_W'(1)) ? T_TAIL : T_BODY;
                    w_load_body = r_mem[r_rd_ptr];
                end
            end
            default: begin
                msg_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dx  <= '0;
            r_dy  <= '0;
            r_len <= '0;
            r_rem <= '0;
        end else begin
            if (w_accept) begin
                r_dx  <= msg_dx;
                r_dy  <= msg_dy;
                r_len <= msg_len;
            end
            if (w_rem_load) begin
                r_rem <= r_len;
            end else if (w_rem_dec) begin
                r_rem <= r_rem - LEN_W'(1);
            end
        end
    end

    // Registered output stage; data only changes on a load, so it holds under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flit_valid <= 1'b0;
            r_flit_data  <= '0;
        end else if (w_load) begin
            r_flit_valid <= 1'b1;
            r_flit_data  <= {w_load_type, w_load_body};
        end else if (flit_ready) begin
            r_flit_valid <= 1'b0;
        end
    end

    assign flit_valid = r_flit_valid;
    assign flit_data  = r_flit_data;

`ifdef NOC_NI_STATS_EN
    logic        w_hs;
    logic [15:0] r_stat_pkts;
    logic [15:0] r_stat_flits;

    assign w_hs = r_flit_valid && flit_ready;

    // Type bit 0 is set only for head-bearing flits (01 and 11).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_pkts  <= '0;
            r_stat_flits <= '0;
        end else if (w_hs) begin
            r_stat_flits <= r_stat_flits + 16'd1;
            if (r_flit_data[DATA_W]) begin
                r_stat_pkts <= r_stat_pkts + 16'd1;
            end
        end
    end

    assign stat_pkts  = r_stat_pkts;
    assign stat_flits = r_stat_flits;
`endif

endmodule

// File: tb/tb_noc_ni_tx.sv
// Self-checking bench for noc_ni_tx: directed scenarios plus randomized traffic checked against a
// message-level model (head + len payload words, tail on the last) built from recorded transactions.
module tb_noc_ni_tx;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned X_W    = 2;
    localparam int unsigned Y_W    = 2;
    localparam int unsigned SRC_X  = 0;
    localparam int unsigned SRC_Y  = 0;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned DEPTH  = 4;

    typedef struct packed {
        logic [1:0] dx;
        logic [1:0] dy;
        logic [3:0] len;
    } msg_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        msg_valid;
    logic        msg_ready;
    logic [1:0]  msg_dx;
    logic [1:0]  msg_dy;
    logic [3:0]  msg_len;
    logic        pld_valid;
    logic        pld_ready;
    logic [31:0] pld_data;
    logic        flit_valid;
    logic        flit_ready;
    logic [33:0] flit_data;
`ifdef NOC_NI_STATS_EN
    logic [15:0] stat_pkts;
    logic [15:0] stat_flits;
`endif

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    bit          rnd_done;

    logic [33:0] obs_q[$];
    int          obs_cyc[$];
    logic [33:0] exp_q[$];
    logic [31:0] word_q[$];
    msg_t        msg_q[$];

    noc_ni_tx #(
        .DATA_W    (DATA_W),
        .X_W       (X_W),
        .Y_W       (Y_W),
        .SRC_X     (SRC_X),
        .SRC_Y     (SRC_Y),
        .LEN_W     (LEN_W),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .msg_dx    (msg_dx),
        .msg_dy    (msg_dy),
        .msg_len   (msg_len),
        .pld_valid (pld_valid),
        .pld_ready (pld_ready),
        .pld_data  (pld_data),
        .flit_valid(flit_valid),
        .flit_ready(flit_ready),
        .flit_data (flit_data)
`ifdef NOC_NI_STATS_EN
        ,
        .stat_pkts (stat_pkts),
        .stat_flits(stat_flits)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every flit handshake that the next rising edge will complete.
    always @(negedge clk) begin
        if (!rst && flit_valid && flit_ready) begin
            obs_q.push_back(flit_data);
            obs_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [33:0] head_flit(input msg_t m);
        int unsigned body;
        body = (int'(m.dx) * 1024) + (int'(m.dy) * 256) + (SRC_X * 64) + (SRC_Y * 16) + int'(m.len);
        return {(m.len == 4'd0) ? 2'b11 : 2'b01, body};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        obs_q.delete();
        obs_cyc.delete();
        exp_q.delete();
        word_q.delete();
        msg_q.delete();
    endtask

    // Expected stream: each message is its head followed by the next len words, last one tagged tail.
    task automatic build_expected();
        int unsigned wi = 0;
        exp_q.delete();
        foreach (msg_q[m]) begin
            exp_q.push_back(head_flit(msg_q[m]));
            for (int unsigned k = 0; k < msg_q[m].len; k++) begin
                if (wi < word_q.size()) begin
                    exp_q.push_back({(k == msg_q[m].len - 1) ? 2'b10 : 2'b00, word_q[wi]});
                end
                wi++;
            end
        end
    endtask

    task automatic push_word(input logic [31:0] d);
        int unsigned n = 0;
        pld_data  = d;
        pld_valid = 1'b1;
        @(negedge clk);
        while (pld_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (pld_ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL push_timeout: pld_ready=%b required 1", pld_ready);
            pld_valid = 1'b0;
            tick();
        end else begin
            tick();
            pld_valid = 1'b0;
            word_q.push_back(d);
        end
    endtask

    task automatic send_msg(input msg_t m);
        int unsigned n = 0;
        msg_dx    = m.dx;
        msg_dy    = m.dy;
        msg_len   = m.len;
        msg_valid = 1'b1;
        @(negedge clk);
        while (msg_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (msg_ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL msg_timeout: msg_ready=%b required 1", msg_ready);
            msg_valid = 1'b0;
            tick();
        end else begin
            tick();
            msg_valid = 1'b0;
            msg_q.push_back(m);
        end
    endtask

    task automatic wait_obs(input int unsigned n, input int unsigned budget);
        int unsigned k = 0;
        while (obs_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (obs_q.size() < n) begin
            tests++;
            fails++;
            $display("FAIL flit_timeout: got %0d flits required %0d", obs_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; msg_valid = 1'b0; pld_valid = 1'b0; flit_ready = 1'b0;
        msg_dx = '0; msg_dy = '0; msg_len = '0; pld_data = '0;
        repeat (3) tick();
        @(negedge clk);
        tests++; if (msg_ready !== 1'b0) begin fails++; $display("FAIL rst_msg_ready: got %b required 0", msg_ready); end
        tests++; if (pld_ready !== 1'b0) begin fails++; $display("FAIL rst_pld_ready: got %b required 0", pld_ready); end
        tests++; if (flit_valid !== 1'b0) begin fails++; $display("FAIL rst_flit_valid: got %b required 0", flit_valid); end
        tests++; if (flit_data !== 34'h0) begin fails++; $display("FAIL rst_flit_data: got %h required 0", flit_data); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        tests++; if (msg_ready !== 1'b1) begin fails++; $display("FAIL post_rst_msg_ready: got %b required 1", msg_ready); end
        tests++; if (pld_ready !== 1'b1) begin fails++; $display("FAIL post_rst_pld_ready: got %b required 1", pld_ready); end
`ifdef NOC_NI_STATS_EN
        tests++; if (stat_pkts !== 16'd0 || stat_flits !== 16'd0) begin
            fails++; $display("FAIL rst_stats: got %0d/%0d required 0/0", stat_pkts, stat_flits);
        end
`endif
        tick();
    endtask

    task automatic test_single();
        msg_t m;
        clear_model();
        flit_ready = 1'b1;
        m = '{dx: 2'd3, dy: 2'd1, len: 4'd0};
        send_msg(m);
        @(negedge clk);
        tests++; if (flit_valid !== 1'b0) begin fails++; $display("FAIL single_early: flit_valid=%b required 0", flit_valid); end
        tick();
        @(negedge clk);
        tests++; if (flit_valid !== 1'b1) begin fails++; $display("FAIL single_latency: flit_valid=%b required 1", flit_valid); end
        tests++; if (flit_data !== 34'h3_0000_0D00) begin fails++; $display("FAIL single_data: got %h required %h", flit_data, 34'h3_0000_0D00); end
        tests++; if (msg_ready !== 1'b1) begin fails++; $display("FAIL single_msg_ready: got %b required 1", msg_ready); end
        repeat (4) tick();
        @(negedge clk);
        tests++; if (obs_q.size() !== 1) begin fails++; $display("FAIL single_count: got %0d flits required 1", obs_q.size()); end
        tests++; if (flit_valid !== 1'b0) begin fails++; $display("FAIL single_idle: flit_valid=%b required 0", flit_valid); end
        tick();
    endtask

    task automatic test_streaming();
        msg_t m;
        clear_model();
        flit_ready = 1'b1;
        for (int i = 0; i < 3; i++) push_word($urandom);
        m = '{dx: 2'($urandom_range(0, 3)), dy: 2'($urandom_range(0, 3)), len: 4'd3};
        send_msg(m);
        wait_obs(4, 20);
        repeat (3) tick();
        build_expected();
        tests++; if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL stream_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            tests++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL stream_flit%0d: got %h required %h", i, obs_q[i], exp_q[i]); end
        end
        for (int i = 1; i < obs_cyc.size(); i++) begin
            tests++; if (obs_cyc[i] !== obs_cyc[0] + i) begin fails++; $display("FAIL stream_gap%0d: cycle %0d required %0d", i, obs_cyc[i], obs_cyc[0] + i); end
        end
    endtask

    task automatic test_backpressure();
        msg_t        m;
        int unsigned n = 0;
`ifdef NOC_NI_STATS_EN
        logic [15:0] p0, f0;
        p0 = stat_pkts;
        f0 = stat_flits;
`endif
        clear_model();
        flit_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_word($urandom);
        m = '{dx: 2'($urandom_range(0, 3)), dy: 2'($urandom_range(0, 3)), len: 4'd3};
        send_msg(m);
        @(negedge clk);
        while (flit_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        for (int i = 0; i < 5; i++) begin
            tests++; if (flit_valid !== 1'b1 || flit_data !== head_flit(m)) begin
                fails++; $display("FAIL bp_hold%0d: got %b/%h required 1/%h", i, flit_valid, flit_data, head_flit(m));
            end
            @(negedge clk);
        end
        tick();
        flit_ready = 1'b1;
        wait_obs(4, 20);
        repeat (3) tick();
        build_expected();
        tests++; if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL bp_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            tests++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL bp_flit%0d: got %h required %h", i, obs_q[i], exp_q[i]); end
        end
`ifdef NOC_NI_STATS_EN
        tests++; if (16'(stat_flits - f0) !== 16'd4 || 16'(stat_pkts - p0) !== 16'd1) begin
            fails++; $display("FAIL bp_stats: got flits+%0d pkts+%0d required 4/1", 16'(stat_flits - f0), 16'(stat_pkts - p0));
        end
`endif
    endtask

    task automatic test_fifo_full();
        msg_t m;
        clear_model();
        flit_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) push_word($urandom);
        @(negedge clk);
        tests++; if (pld_ready !== 1'b0) begin fails++; $display("FAIL full_ready: got %b required 0", pld_ready); end
        tick();
        m = '{dx: 2'($urandom_range(0, 3)), dy: 2'($urandom_range(0, 3)), len: 4'd6};
        fork
            begin
                push_word($urandom);
                push_word($urandom);
            end
            send_msg(m);
        join
        wait_obs(7, 40);
        repeat (3) tick();
        build_expected();
        tests++; if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL full_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            tests++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL full_flit%0d: got %h required %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_bubble();
        msg_t        m;
        logic [31:0] w2;
        clear_model();
        flit_ready = 1'b1;
        push_word($urandom);
        m = '{dx: 2'($urandom_range(0, 3)), dy: 2'($urandom_range(0, 3)), len: 4'd2};
        send_msg(m);
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++; if (flit_valid !== 1'b0) begin fails++; $display("FAIL bubble_gap%0d: flit_valid=%b required 0", i, flit_valid); end
            tick();
        end
        w2 = $urandom;
        push_word(w2);
        @(negedge clk);
        tests++; if (flit_valid !== 1'b0) begin fails++; $display("FAIL bubble_early: flit_valid=%b required 0", flit_valid); end
        tick();
        @(negedge clk);
        tests++; if (flit_valid !== 1'b1 || flit_data !== {2'b10, w2}) begin
            fails++; $display("FAIL bubble_tail: got %b/%h required 1/%h", flit_valid, flit_data, {2'b10, w2});
        end
        wait_obs(3, 10);
        repeat (2) tick();
        build_expected();
        tests++; if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL bubble_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            tests++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL bubble_flit%0d: got %h required %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        msg_t        m;
        logic [31:0] w[4];
        clear_model();
        flit_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w[i] = $urandom;
            push_word(w[i]);
        end
        m = '{dx: 2'($urandom_range(0, 3)), dy: 2'($urandom_range(0, 3)), len: 4'd5};
        send_msg(m);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        tests++; if (flit_valid !== 1'b0) begin fails++; $display("FAIL rmid_valid: got %b required 0", flit_valid); end
        tests++; if (msg_ready !== 1'b1) begin fails++; $display("FAIL rmid_msg_ready: got %b required 1", msg_ready); end
        tests++; if (obs_q.size() !== 3) begin fails++; $display("FAIL rmid_count: got %0d required 3", obs_q.size()); end
        if (obs_q.size() >= 3) begin
            tests++; if (obs_q[0] !== head_flit(m)) begin fails++; $display("FAIL rmid_head: got %h required %h", obs_q[0], head_flit(m)); end
            tests++; if (obs_q[1] !== {2'b00, w[0]}) begin fails++; $display("FAIL rmid_b1: got %h required %h", obs_q[1], {2'b00, w[0]}); end
            tests++; if (obs_q[2] !== {2'b00, w[1]}) begin fails++; $display("FAIL rmid_b2: got %h required %h", obs_q[2], {2'b00, w[1]}); end
        end
        tick();
        clear_model();
        m = '{dx: 2'($urandom_range(0, 3)), dy: 2'($urandom_range(0, 3)), len: 4'd0};
        send_msg(m);
        m = '{dx: 2'($urandom_range(0, 3)), dy: 2'($urandom_range(0, 3)), len: 4'd1};
        send_msg(m);
        wait_obs(2, 20);
        // A flushed FIFO must leave the second packet waiting for fresh payload.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++; if (flit_valid !== 1'b0) begin fails++; $display("FAIL rmid_flushed%0d: flit_valid=%b required 0", i, flit_valid); end
            tick();
        end
        push_word($urandom);
        wait_obs(3, 20);
        repeat (2) tick();
        build_expected();
        tests++; if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL rmid_post_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            tests++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL rmid_post%0d: got %h required %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        msg_t        msgs[10];
        int unsigned nwords = 0;
        int unsigned total;
        logic [33:0] pd;
        logic        pv;
        logic        pr;
`ifdef NOC_NI_STATS_EN
        logic [15:0] p0, f0;
        p0 = stat_pkts;
        f0 = stat_flits;
`endif
        clear_model();
        rnd_done = 1'b0;
        foreach (msgs[i]) begin
            msgs[i] = '{dx: 2'($urandom_range(0, 3)), dy: 2'($urandom_range(0, 3)), len: 4'($urandom_range(0, 15))};
            nwords += msgs[i].len;
        end
        total = nwords + 10;
        fork
            begin
                foreach (msgs[i]) begin
                    repeat ($urandom_range(0, 3)) tick();
                    send_msg(msgs[i]);
                end
            end
            begin
                for (int unsigned i = 0; i < nwords; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    push_word($urandom);
                end
            end
            begin
                while (!rnd_done) begin
                    flit_ready = ($urandom_range(0, 9) < 7);
                    tick();
                end
                flit_ready = 1'b1;
            end
            begin
                pv = 1'b0; pr = 1'b1; pd = '0;
                while (!rnd_done) begin
                    @(negedge clk);
                    if (pv && !pr) begin
                        tests++; if (flit_valid !== 1'b1 || flit_data !== pd) begin
                            fails++; $display("FAIL rnd_hold: got %b/%h required 1/%h", flit_valid, flit_data, pd);
                        end
                    end
                    pv = flit_valid; pr = flit_ready; pd = flit_data;
                end
            end
            begin
                wait_obs(total, 5000);
                rnd_done = 1'b1;
            end
        join
        repeat (3) tick();
        build_expected();
        tests++; if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL rnd_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            tests++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL rnd_flit%0d: got %h required %h", i, obs_q[i], exp_q[i]); end
        end
`ifdef NOC_NI_STATS_EN
        tests++; if (16'(stat_flits - f0) !== 16'(total) || 16'(stat_pkts - p0) !== 16'd10) begin
            fails++; $display("FAIL rnd_stats: got flits+%0d pkts+%0d required %0d/10", 16'(stat_flits - f0), 16'(stat_pkts - p0), total);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_fifo_full();
        test_bubble();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
